// File: rtl/router_pkg.sv
// Shared router types: port indices, output-arbiter FSM states and the
// arbitration pick result.
package router_pkg;

  localparam int NUM_PORTS = 4;

  typedef logic [1:0] port_idx_t;

  typedef enum logic [1:0] {
    OA_IDLE   = 2'd0,
    OA_REQ    = 2'd1,
    OA_ACK_IN = 2'd2
  } oarb_state_e;

  typedef struct packed {
    logic      vld;
    port_idx_t idx;
  } oarb_pick_t;

endpackage

// File: rtl/handshake_sync.sv
// Multi-flop synchroniser for asynchronous 4-phase req/ack wires.
// SYNC_STAGES must be at least 2.
module handshake_sync #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_pipe;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_pipe <= '0;
    else      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], d};
  end

  assign q = sync_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/output_arbiter4.sv
// Round-robin arbiter/sequencer merging four 4-phase bundled-data channels
// onto one output channel. Define OARB_FIXED_PRIO_EN for strict priority.
module output_arbiter4
  import router_pkg::*;
#(
  parameter int n           = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   in_req,
  output logic [NUM_PORTS-1:0]   in_ack,
  input  logic [NUM_PORTS*n-1:0] in_data,
  output logic                   out_req,
  input  logic                   out_ack,
  output logic [n-1:0]           out_data,
  output port_idx_t              grant_idx,
  output logic                   busy
);

  oarb_state_e                     state;
  port_idx_t                       g;
  port_idx_t                       ptr;
  logic [NUM_PORTS-1:0]            rq_s;
  logic                            ak_s;
  logic [NUM_PORTS-1:0][n-1:0]     flits;
  oarb_pick_t                      pick;

  handshake_sync #(.WIDTH(NUM_PORTS), .SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk (clk),
    .rst (rst),
    .d   (in_req),
    .q   (rq_s)
  );

  handshake_sync #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (out_ack),
    .q   (ak_s)
  );

  assign flits = in_data;

  // Scan base+1, base+2, base+3, base: descending loop so the nearest wins.
  function automatic oarb_pick_t rr_pick(input logic [NUM_PORTS-1:0] cand,
                                         input port_idx_t            base);
    oarb_pick_t p;
    port_idx_t  k;
    p = '0;
    for (int j = NUM_PORTS; j >= 1; j--) begin
      k = base + port_idx_t'(j);
      if (cand[k]) begin
        p.vld = 1'b1;
        p.idx = k;
      end
    end
    return p;
  endfunction

  assign pick = rr_pick(rq_s & ~in_ack, ptr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= OA_IDLE;
      g         <= '0;
      ptr       <= 2'd3;
      out_req   <= 1'b0;
      in_ack    <= '0;
      out_data  <= '0;
      grant_idx <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        OA_IDLE: begin
          if (pick.vld) begin
            g         <= pick.idx;
            grant_idx <= pick.idx;
            out_data  <= flits[pick.idx];
            out_req   <= 1'b1;
            busy      <= 1'b1;
            state     <= OA_REQ;
          end
        end
        OA_REQ: begin
          if (ak_s) begin
            out_req   <= 1'b0;
            in_ack[g] <= 1'b1;
            state     <= OA_ACK_IN;
          end
        end
        OA_ACK_IN: begin
          // Hold in_ack until the requester has released, so a quick
          // re-request is seen as a new transfer.
          if (!rq_s[g] && !ak_s) begin
            in_ack[g] <= 1'b0;
            busy      <= 1'b0;
            state     <= OA_IDLE;
`ifdef OARB_FIXED_PRIO_EN
            ptr       <= ptr;
`else
            ptr       <= g;
`endif
          end
        end
        default: state <= OA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_arbiter4.sv
// Scoreboard bench for output_arbiter4: expected grants are queued as
// stimulus is issued and checked when out_req rises.
module tb_output_arbiter4;
  import router_pkg::*;

  localparam int N  = 8;
  localparam int SS = 2;

  typedef struct packed {
    port_idx_t idx;
    logic [N-1:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [3:0]       in_req = '0;
  logic [3:0]       in_ack;
  logic [4*N-1:0]   in_data = '0;
  logic             out_req;
  logic             out_ack = 1'b0;
  logic [N-1:0]     out_data;
  port_idx_t        grant_idx;
  logic             busy;
  logic             hold = 1'b0;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  output_arbiter4 #(.n(N), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_req    (in_req),
    .in_ack    (in_ack),
    .in_data   (in_data),
    .out_req   (out_req),
    .out_ack   (out_ack),
    .out_data  (out_data),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [N-1:0] d);
    sb.push_back(exp_t'{port_idx_t'(i), d});
  endtask

  task automatic wait_ack(input int i, input logic v, input string tag);
    for (int t = 0; t < 400 && in_ack[i] !== v; t++) @(negedge clk);
    chk(tag, 32'(in_ack[i]), 32'(v));
  endtask

  task automatic agent(input int i, input int cnt, input logic [N-1:0] d);
    for (int k = 0; k < cnt; k++) begin
      in_data[i*N +: N] = d;
      in_req[i] = 1'b1;
      wait_ack(i, 1'b1, "ack_rise");
      in_req[i] = 1'b0;
      wait_ack(i, 1'b0, "ack_fall");
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Downstream: check each new grant, echo out_req as out_ack one cycle later.
  initial begin
    logic req_q;
    exp_t e;
    req_q = 1'b0;
    forever begin
      @(negedge clk);
      if (out_req && !req_q) begin
        if (sb.size() == 0) chk("unexpected_grant", 32'(grant_idx), 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          chk("grant_idx", 32'(grant_idx), 32'(e.idx));
          chk("out_data", 32'(out_data), 32'(e.data));
        end
      end
      out_ack = hold ? 1'b0 : req_q;
      req_q   = out_req;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    chk("rst_out_req", 32'(out_req), 0);
    chk("rst_in_ack", 32'(in_ack), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_grant_idx", 32'(grant_idx), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single request on input 1: latency and in_ack sequence
    push(1, 8'hA5);
    in_data[15:8] = 8'hA5;
    in_req = 4'b0010;
    lat = 0;
    for (int t = 0; t < 20 && !out_req; t++) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, SS + 1);
    wait_ack(1, 1'b1, "t1_ack_rise");
    chk("t1_in_ack", 32'(in_ack), 32'b0010);
    in_req[1] = 1'b0;
    wait_ack(1, 1'b0, "t1_ack_fall");
    chk("t1_in_ack_clr", 32'(in_ack), 0);
    @(negedge clk);
    chk("t1_busy_clr", 32'(busy), 0);

    // All four at once after reset
    do_reset();
    push(0, 8'h11); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44);
    fork
      agent(0, 1, 8'h11);
      agent(1, 1, 8'h22);
      agent(2, 1, 8'h33);
      agent(3, 1, 8'h44);
    join

    // Repeated requests on 0, 2, 3
`ifdef OARB_FIXED_PRIO_EN
    push(0, 8'hC0); push(2, 8'hC2); push(0, 8'hC0);
    push(2, 8'hC2); push(3, 8'hC3); push(3, 8'hC3);
`else
    push(0, 8'hC0); push(2, 8'hC2); push(3, 8'hC3);
    push(0, 8'hC0); push(2, 8'hC2); push(3, 8'hC3);
`endif
    fork
      agent(0, 2, 8'hC0);
      agent(2, 2, 8'hC2);
      agent(3, 2, 8'hC3);
    join

    // out_ack held low: stall in REQ
    hold = 1'b1;
    push(3, 8'hD3);
    fork
      agent(3, 1, 8'hD3);
      begin
        repeat (50) @(negedge clk);
        chk("stall_out_req", 32'(out_req), 1);
        chk("stall_in_ack", 32'(in_ack), 0);
        chk("stall_busy", 32'(busy), 1);
        hold = 1'b0;
      end
    join

    // Reset while in REQ
    hold = 1'b1;
    push(0, 8'hE0);
    in_data = {8'hE3, 8'hE2, 8'hE1, 8'hE0};
    in_req  = 4'hF;
    for (int t = 0; t < 20 && !out_req; t++) @(negedge clk);
    chk("pre_rst_out_req", 32'(out_req), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_out_req", 32'(out_req), 0);
    chk("mid_rst_in_ack", 32'(in_ack), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_out_data", 32'(out_data), 0);
    @(negedge clk);
    rst = 1'b1;
    hold = 1'b0;
    push(0, 8'hE0); push(1, 8'hE1); push(2, 8'hE2); push(3, 8'hE3);
    fork
      agent(0, 1, 8'hE0);
      agent(1, 1, 8'hE1);
      agent(2, 1, 8'hE2);
      agent(3, 1, 8'hE3);
    join

    // Glitch on in_req[2] between clock edges: must be ignored
    @(posedge clk);
    #2 in_req[2] = 1'b1;
    #3 in_req[2] = 1'b0;
    repeat (10) @(negedge clk);
    chk("glitch_busy", 32'(busy), 0);
    chk("glitch_in_ack", 32'(in_ack), 0);
    chk("glitch_out_req", 32'(out_req), 0);
    push(2, 8'hF2);
    agent(2, 1, 8'hF2);

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
